shuffled_card_deck: RTL and testbench

Card source that answers the hand FSM's deck requests. It holds a 52-card permutation in registers and shuffles it in place with a seeded LFSR using Fisher-Yates. On request it presents and pops cards one at a time. The hand FSM sees top_card/ready; shuffle start and draws are single-bit requests from the hand FSM.

---
 rtl/poker_types.sv | 51 +++++
 rtl/lfsr16.sv | 38 +++
 rtl/shuffled_card_deck.sv | 125 ++++++++++++
 tb/tb_shuffled_card_deck.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poker_types.sv
// Shared card, deck and LFSR types for the poker table datapath.
package poker_types;
  localparam int DECK_SIZE = 52;
  localparam int CARD_IDX_W = 6;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic [CARD_IDX_W-1:0] card_idx_t;

  typedef enum logic [3:0] {
    RANK_TWO, RANK_THREE, RANK_FOUR, RANK_FIVE, RANK_SIX, RANK_SEVEN, RANK_EIGHT,
    RANK_NINE, RANK_TEN, RANK_JACK, RANK_QUEEN, RANK_KING, RANK_ACE
  } rank_t;

  typedef enum logic [1:0] {SUIT_CLUBS, SUIT_DIAMONDS, SUIT_HEARTS, SUIT_SPADES} suit_t;

  typedef struct packed {
    rank_t rank;
    suit_t suit;
  } card_t;

  typedef enum logic [1:0] {ST_UNSHUFFLED, ST_SHUFFLING, ST_DEALING, ST_EMPTY} deck_state_t;

  // suit = idx/13, rank = idx%13, done with compares instead of a divider
  function automatic card_t idx_to_card(input card_idx_t idx);
    card_t c;
    if (idx >= 6'd39) begin
      c.suit = SUIT_SPADES;
      c.rank = rank_t'(4'(idx - 6'd39));
    end else if (idx >= 6'd26) begin
      c.suit = SUIT_HEARTS;
      c.rank = rank_t'(4'(idx - 6'd26));
    end else if (idx >= 6'd13) begin
      c.suit = SUIT_DIAMONDS;
      c.rank = rank_t'(4'(idx - 6'd13));
    end else begin
      c.suit = SUIT_CLUBS;
      c.rank = rank_t'(4'(idx));
    end
    return c;
  endfunction

  // All-ones mask covering the bit-length of i (smear the top set bit down).
  function automatic card_idx_t bit_mask(input card_idx_t i);
    card_idx_t m;
    m = i | (i >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    return m;
  endfunction
endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR stepping every cycle, with seed load and zero-seed guard.
module lfsr16 #(
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1,
  parameter logic [15:0] TAPS         = 16'hB400,
  parameter int          OUT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_seed,
  input  logic [15:0]      seed,
  output logic [OUT_W-1:0] value
);
  logic [15:0] lfsr_r;
  logic [15:0] lfsr_next_s;

  // Next LFSR value: a load beats a step, and an all-zero seed would lock up.
  always_comb begin
    lfsr_next_s = {1'b0, lfsr_r[15:1]};
    if (load_seed) begin
      lfsr_next_s = (seed == 16'h0000) ? DEFAULT_SEED : seed;
    end else if (lfsr_r[0]) begin
      lfsr_next_s = {1'b0, lfsr_r[15:1]} ^ TAPS;
    end else begin
      lfsr_next_s = {1'b0, lfsr_r[15:1]};
    end
  end

  // LFSR state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_r <= DEFAULT_SEED;
    end else begin
      lfsr_r <= lfsr_next_s;
    end
  end

  assign value = lfsr_r[OUT_W-1:0];
endmodule

// File: rtl/shuffled_card_deck.sv
// 52-card deck held in registers, shuffled in place (Fisher-Yates with LFSR
// rejection sampling) and dealt one card per accepted draw.
module shuffled_card_deck
  import poker_types::*;
#(
  parameter logic [15:0] DEFAULT_SEED = LFSR_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_shuffle,
  input  logic        draw_card,
  input  logic        load_seed,
  input  logic [15:0] seed,
  output card_t       top_card,
  output logic        ready,
  output logic        dealable,
  output logic [5:0]  cards_remaining,
  output logic        empty
);
  deck_state_t state_r, state_next_s;
  card_idx_t   deck_r [DECK_SIZE];
  card_idx_t   ptr_r, ptr_next_s;
  card_idx_t   i_r, i_next_s;
  card_idx_t   rem_r, rem_next_s;
  logic        ready_r, ready_next_s;
  logic [5:0]  rnd_s;
  card_idx_t   r_s;
  logic        swap_s;

  lfsr16 #(.DEFAULT_SEED(DEFAULT_SEED), .TAPS(LFSR_TAPS), .OUT_W(6)) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load_seed(load_seed),
    .seed     (seed),
    .value    (rnd_s)
  );

  assign r_s = rnd_s & bit_mask(i_r);

  // Next-state logic; start_shuffle overrides everything, including a draw.
  always_comb begin
    state_next_s = state_r;
    ptr_next_s   = ptr_r;
    i_next_s     = i_r;
    rem_next_s   = rem_r;
    ready_next_s = ready_r;
    swap_s       = 1'b0;
    if (start_shuffle) begin
      state_next_s = ST_SHUFFLING;
      i_next_s     = 6'd51;
      ptr_next_s   = 6'd0;
      rem_next_s   = 6'd0;
      ready_next_s = 1'b0;
    end else begin
      case (state_r)
        ST_SHUFFLING: begin
          if (r_s <= i_r) begin
            swap_s = 1'b1;
            if (i_r == 6'd1) begin
              state_next_s = ST_DEALING;
              ready_next_s = 1'b1;
              rem_next_s   = 6'd52;
            end else begin
              i_next_s = i_r - 6'd1;
            end
          end else begin
            swap_s = 1'b0;
          end
        end
        ST_DEALING: begin
          if (draw_card) begin
            ready_next_s = 1'b0;
            rem_next_s   = rem_r - 6'd1;
            // The last card stays on top once the deck runs out.
            if (rem_r == 6'd1) begin
              state_next_s = ST_EMPTY;
            end else begin
              ptr_next_s = ptr_r + 6'd1;
            end
          end else begin
            ready_next_s = ready_r;
          end
        end
        default: begin
          state_next_s = state_r;
        end
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_UNSHUFFLED;
      ptr_r   <= 6'd0;
      i_r     <= 6'd51;
      rem_r   <= 6'd0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      ptr_r   <= ptr_next_s;
      i_r     <= i_next_s;
      rem_r   <= rem_next_s;
      ready_r <= ready_next_s;
    end
  end

  // Deck storage: identity on reset, one swap per accepted shuffle step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DECK_SIZE; k++) begin
        deck_r[k] <= card_idx_t'(k);
      end
    end else if (swap_s) begin
      deck_r[i_r] <= deck_r[r_s];
      deck_r[r_s] <= deck_r[i_r];
    end
  end

  assign top_card        = idx_to_card(deck_r[ptr_r]);
  assign ready           = ready_r;
  assign dealable        = (state_r == ST_DEALING);
  assign empty           = (state_r == ST_EMPTY);
  assign cards_remaining = rem_r;
endmodule

// File: tb/tb_shuffled_card_deck.sv
// Randomized self-checking bench for shuffled_card_deck against a Fisher-Yates reference model.
module tb_shuffled_card_deck;
  logic        clk, reset, start_shuffle, draw_card, load_seed;
  logic [15:0] seed;
  logic [5:0]  top_card;
  logic        ready, dealable, empty;
  logic [5:0]  cards_remaining;

  int          vectors, miscompares;
  logic [15:0] m_lfsr;
  int          m_deck [52];
  int          first_perm [52];
  logic [5:0]  got [52];

  shuffled_card_deck dut (
    .clk(clk), .reset(reset), .start_shuffle(start_shuffle), .draw_card(draw_card),
    .load_seed(load_seed), .seed(seed), .top_card(top_card), .ready(ready),
    .dealable(dealable), .cards_remaining(cards_remaining), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  function automatic logic [5:0] exp_card(input int idx);
    logic [3:0] rk;
    logic [1:0] st;
    rk = 4'(idx % 13);
    st = 2'(idx / 13);
    return {rk, st};
  endfunction

  function automatic int card_idx(input logic [5:0] c);
    return int'(c[1:0]) * 13 + int'(c[5:2]);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 52; k++) m_deck[k] = k;
    m_lfsr = 16'hACE1;
  endfunction

  // Fisher-Yates with rejection sampling, one random draw per cycle; returns cycles used.
  function automatic int model_shuffle(input logic [15:0] l0, input int max_cycles);
    int i, r, m, c, tmp;
    logic [15:0] l;
    i = 51; c = 0; l = l0;
    while (i >= 1 && c < max_cycles) begin
      m = (1 << $clog2(i + 1)) - 1;
      r = int'(l[5:0]) & m;
      if (r <= i) begin
        tmp = m_deck[i]; m_deck[i] = m_deck[r]; m_deck[r] = tmp;
        i--;
      end
      l = lfsr_step(l);
      c++;
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!reset) m_lfsr = 16'hACE1;
    else if (load_seed) m_lfsr = (seed == 16'h0000) ? 16'hACE1 : seed;
    else m_lfsr = lfsr_step(m_lfsr);
    #1;
  endtask

  task automatic run_shuffle(input logic ld, input logic [15:0] sd, output int gc, output int ec);
    load_seed = ld; seed = sd; start_shuffle = 1'b1;
    tick();
    load_seed = 1'b0; start_shuffle = 1'b0;
    ec = model_shuffle(m_lfsr, 100000);
    gc = 0;
    while (ready !== 1'b1 && gc < 2000) begin
      tick();
      gc++;
    end
  endtask

  task automatic draw_all();
    draw_card = 1'b1;
    for (int n = 0; n < 52; n++) begin
      got[n] = top_card;
      tick();
    end
    draw_card = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start_shuffle = 1'b0; draw_card = 1'b0; load_seed = 1'b0; seed = 16'h0000;
    model_reset();
    tick();
    vectors++;
    if ({ready, dealable, empty, cards_remaining, top_card} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_state got r%b d%b e%b cr%0d top%h want all zero",
               ready, dealable, empty, cards_remaining, top_card);
    end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_draw_unshuffled();
    draw_card = 1'b1;
    repeat (3) tick();
    draw_card = 1'b0;
    vectors++;
    if (cards_remaining !== 6'd0 || dealable !== 1'b0 || ready !== 1'b0 || top_card !== exp_card(0)) begin
      miscompares++;
      $display("FAIL unshuffled_draw got cr%0d d%b r%b top%h want cr0 d0 r0 top%h",
               cards_remaining, dealable, ready, top_card, exp_card(0));
    end
  endtask

  task automatic test_golden_deal();
    int gc, ec, distinct;
    bit seen [52];
    run_shuffle(1'b1, 16'h0001, gc, ec);
    vectors++;
    if (gc !== ec) begin
      miscompares++;
      $display("FAIL shuffle_cycles got %0d want %0d", gc, ec);
    end
    vectors++;
    if (ready !== 1'b1 || dealable !== 1'b1 || cards_remaining !== 6'd52) begin
      miscompares++;
      $display("FAIL shuffled_flags got r%b d%b cr%0d want r1 d1 cr52", ready, dealable, cards_remaining);
    end
    for (int k = 0; k < 52; k++) begin first_perm[k] = m_deck[k]; seen[k] = 1'b0; end
    distinct = 0;
    draw_card = 1'b1;
    for (int n = 0; n < 52; n++) begin
      vectors++;
      if (top_card !== exp_card(m_deck[n]) || cards_remaining !== 6'(52 - n)) begin
        miscompares++;
        $display("FAIL golden_card_%0d got top%h cr%0d want top%h cr%0d",
                 n, top_card, cards_remaining, exp_card(m_deck[n]), 52 - n);
      end
      if (card_idx(top_card) < 52 && !seen[card_idx(top_card)]) begin
        seen[card_idx(top_card)] = 1'b1;
        distinct++;
      end
      tick();
      if (n == 0) begin
        vectors++;
        if (ready !== 1'b0) begin
          miscompares++;
          $display("FAIL ready_after_draw got %b want 0", ready);
        end
      end
    end
    vectors++;
    if (distinct !== 52) begin
      miscompares++;
      $display("FAIL distinct_cards got %0d want 52", distinct);
    end
    vectors++;
    if (empty !== 1'b1 || dealable !== 1'b0 || cards_remaining !== 6'd0 || top_card !== exp_card(m_deck[51])) begin
      miscompares++;
      $display("FAIL empty_state got e%b d%b cr%0d top%h want e1 d0 cr0 top%h",
               empty, dealable, cards_remaining, top_card, exp_card(m_deck[51]));
    end
    tick();
    draw_card = 1'b0;
    vectors++;
    if (cards_remaining !== 6'd0 || top_card !== exp_card(m_deck[51]) || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL draw_53 got cr%0d top%h e%b want cr0 top%h e1",
               cards_remaining, top_card, empty, exp_card(m_deck[51]));
    end
  endtask

  task automatic test_back_to_back();
    int gc, ec;
    run_shuffle(1'b0, 16'h0000, gc, ec);
    vectors++;
    if (gc !== ec) begin
      miscompares++;
      $display("FAIL reshuffle_cycles got %0d want %0d", gc, ec);
    end
    draw_card = 1'b1;
    tick();
    tick();
    draw_card = 1'b0;
    vectors++;
    if (cards_remaining !== 6'd50 || top_card !== exp_card(m_deck[2]) || ready !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_draw_two got cr%0d top%h r%b want cr50 top%h r0",
               cards_remaining, top_card, ready, exp_card(m_deck[2]));
    end
  endtask

  task automatic test_random_deal();
    int gc, ec, m_ptr, m_rem;
    bit d, drawn;
    for (int t = 0; t < 4; t++) begin
      // odd trials hold draw_card through start and shuffle: those draws must be dropped
      draw_card = t[0];
      run_shuffle(1'b1, (t == 2) ? 16'h0000 : 16'($urandom), gc, ec);
      vectors++;
      if (gc !== ec) begin
        miscompares++;
        $display("FAIL rand_cycles_%0d got %0d want %0d", t, gc, ec);
      end
      m_ptr = 0; m_rem = 52; drawn = 1'b0;
      for (int c = 0; c < 100; c++) begin
        d = ($urandom_range(0, 3) != 0);
        draw_card = d;
        tick();
        if (d && m_rem > 0) begin
          m_rem--;
          drawn = 1'b1;
          if (m_rem > 0) m_ptr++;
        end
        vectors++;
        if (top_card !== exp_card(m_deck[m_ptr]) || cards_remaining !== 6'(m_rem) ||
            dealable !== (m_rem > 0) || empty !== (m_rem == 0) || ready !== !drawn) begin
          miscompares++;
          $display("FAIL rand_deal_%0d_%0d got top%h cr%0d d%b e%b r%b want top%h cr%0d",
                   t, c, top_card, cards_remaining, dealable, empty, ready,
                   exp_card(m_deck[m_ptr]), m_rem);
        end
      end
      draw_card = 1'b0;
    end
  endtask

  task automatic test_restart();
    int gc, ec, distinct;
    bit seen [52];
    load_seed = 1'b1; seed = 16'($urandom); start_shuffle = 1'b1;
    tick();
    load_seed = 1'b0; start_shuffle = 1'b0;
    void'(model_shuffle(m_lfsr, 5));
    repeat (5) tick();
    start_shuffle = 1'b1;
    tick();
    start_shuffle = 1'b0;
    vectors++;
    if (ready !== 1'b0 || dealable !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_ready got r%b d%b want r0 d0", ready, dealable);
    end
    ec = model_shuffle(m_lfsr, 100000);
    gc = 0;
    while (ready !== 1'b1 && gc < 2000) begin
      tick();
      gc++;
      if (ready !== 1'b1 && gc < ec) begin
        vectors++;
        if (dealable !== 1'b0) begin
          miscompares++;
          $display("FAIL restart_dealable got %b want 0", dealable);
        end
      end
    end
    vectors++;
    if (gc !== ec) begin
      miscompares++;
      $display("FAIL restart_cycles got %0d want %0d", gc, ec);
    end
    draw_all();
    for (int k = 0; k < 52; k++) seen[k] = 1'b0;
    distinct = 0;
    for (int n = 0; n < 52; n++) begin
      vectors++;
      if (got[n] !== exp_card(m_deck[n])) begin
        miscompares++;
        $display("FAIL restart_card_%0d got %h want %h", n, got[n], exp_card(m_deck[n]));
      end
      if (card_idx(got[n]) < 52 && !seen[card_idx(got[n])]) begin
        seen[card_idx(got[n])] = 1'b1;
        distinct++;
      end
    end
    vectors++;
    if (distinct !== 52) begin
      miscompares++;
      $display("FAIL restart_perm got %0d distinct want 52", distinct);
    end
  endtask

  task automatic test_reset_mid();
    int gc, ec;
    load_seed = 1'b1; seed = 16'h5A5A; start_shuffle = 1'b1;
    tick();
    load_seed = 1'b0; start_shuffle = 1'b0;
    repeat (10) tick();
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({ready, dealable, empty, cards_remaining, top_card} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_mid_shuffle got r%b d%b e%b cr%0d top%h want all zero",
               ready, dealable, empty, cards_remaining, top_card);
    end
    tick();
    reset = 1'b1;
    model_reset();
    run_shuffle(1'b1, 16'h1234, gc, ec);
    draw_card = 1'b1;
    repeat (3) tick();
    draw_card = 1'b0;
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({ready, dealable, empty, cards_remaining, top_card} !== 15'd0) begin
      miscompares++;
      $display("FAIL reset_mid_deal got r%b d%b e%b cr%0d top%h want all zero",
               ready, dealable, empty, cards_remaining, top_card);
    end
    tick();
    reset = 1'b1;
    model_reset();
    run_shuffle(1'b1, 16'h0001, gc, ec);
    vectors++;
    if (gc !== ec) begin
      miscompares++;
      $display("FAIL repro_cycles got %0d want %0d", gc, ec);
    end
    draw_all();
    for (int n = 0; n < 52; n++) begin
      vectors++;
      if (got[n] !== exp_card(first_perm[n])) begin
        miscompares++;
        $display("FAIL repro_card_%0d got %h want %h", n, got[n], exp_card(first_perm[n]));
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_draw_unshuffled();
    test_golden_deal();
    test_back_to_back();
    test_random_deal();
    test_restart();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
